// File: rtl/stopwatch_pkg.sv
// Shared state encoding, display record and default timing constants for the stopwatch controller.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUNNING = 2'd1,
    ST_LAP     = 2'd2,
    ST_PAUSED  = 2'd3
  } sw_state_t;

  typedef struct packed {
    logic [7:0] h;
    logic [7:0] m;
    logic [7:0] s;
  } hms_t;

  localparam int unsigned DEF_TICK_DIV   = 50_000_000;
  localparam int unsigned DEF_DEB_CYCLES = 500_000;

endpackage

// File: rtl/stopwatch_ctrl_btn_cond.sv
// Button conditioner: 2-flop synchronizer, stability debounce, rising-edge event.
// A button already held when reset lifts is ignored until it has been seen released.
module btn_cond
  import stopwatch_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEF_DEB_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic ev
);

  localparam int unsigned CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          deb;
  logic          deb_prev;
  logic          armed;
  logic [CW-1:0] cnt;

  // The synchronizer keeps sampling through reset so a held button is already visible afterwards.
  always_ff @(posedge clk) begin
    sync1 <= btn;
    sync2 <= sync1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      deb      <= 1'b0;
      deb_prev <= 1'b0;
      armed    <= 1'b0;
      cnt      <= '0;
    end else begin
      deb_prev <= deb;
      if (!sync2 && !deb)
        armed <= 1'b1;
      if (sync2 == deb) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        deb <= sync2;
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign ev = deb & ~deb_prev & armed;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch front panel: conditions three buttons, sequences the timer via one-cycle pulses,
// generates the advance strobe and freezes a lap snapshot on the display.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned TICK_DIV   = DEF_TICK_DIV,
  parameter int unsigned DEB_CYCLES = DEF_DEB_CYCLES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_ss,
  input  logic       btn_lap,
  input  logic       btn_clr,
  input  logic [7:0] th,
  input  logic [7:0] tm,
  input  logic [7:0] ts,
  output logic       tmr_ss,
  output logic       tmr_clr,
  output logic       tick,
  output logic [7:0] disp_h,
  output logic [7:0] disp_m,
  output logic [7:0] disp_s,
  output logic [1:0] state
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  sw_state_t     st;
  logic [PW-1:0] pre;
  hms_t          lap_q;
  hms_t          disp_q;
  hms_t          live;
  logic          ev_ss;
  logic          ev_lap;
  logic          ev_clr;

  btn_cond #(.DEB_CYCLES(DEB_CYCLES)) u_ss  (.clk(clk), .reset(reset), .btn(btn_ss),  .ev(ev_ss));
  btn_cond #(.DEB_CYCLES(DEB_CYCLES)) u_lap (.clk(clk), .reset(reset), .btn(btn_lap), .ev(ev_lap));
  btn_cond #(.DEB_CYCLES(DEB_CYCLES)) u_clr (.clk(clk), .reset(reset), .btn(btn_clr), .ev(ev_clr));

  assign live = '{h: th, m: tm, s: ts};

  // Each state tests only the events valid in it, in clr > ss > lap order.
  always_ff @(posedge clk) begin
    if (reset) begin
      st      <= ST_IDLE;
      tmr_ss  <= 1'b0;
      tmr_clr <= 1'b0;
      tick    <= 1'b0;
      pre     <= '0;
      lap_q   <= '0;
    end else begin
      tmr_ss  <= 1'b0;
      tmr_clr <= 1'b0;
      tick    <= 1'b0;
      if (st == ST_RUNNING || st == ST_LAP) begin
        if (pre == PRE_LAST) begin
          pre  <= '0;
          tick <= 1'b1;
        end else begin
          pre <= pre + PW'(1);
        end
      end
      case (st)
        ST_IDLE: begin
          if (ev_ss) begin
            st     <= ST_RUNNING;
            tmr_ss <= 1'b1;
          end
        end
        ST_RUNNING: begin
          if (ev_ss) begin
            st     <= ST_PAUSED;
            tmr_ss <= 1'b1;
          end else if (ev_lap) begin
            st    <= ST_LAP;
            lap_q <= live;
          end
        end
        ST_LAP: begin
          if (ev_ss) begin
            st     <= ST_PAUSED;
            tmr_ss <= 1'b1;
          end else if (ev_lap) begin
            st <= ST_RUNNING;
          end
        end
        ST_PAUSED: begin
          if (ev_clr) begin
            st      <= ST_IDLE;
            tmr_clr <= 1'b1;
            pre     <= '0;
          end else if (ev_ss) begin
            st     <= ST_RUNNING;
            tmr_ss <= 1'b1;
          end
        end
        default: st <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      disp_q <= '0;
    else
      disp_q <= (st == ST_LAP) ? lap_q : live;
  end

  assign disp_h = disp_q.h;
  assign disp_m = disp_q.m;
  assign disp_s = disp_q.s;
  assign state  = st;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with a per-cycle behavioural reference model.
module tb_stopwatch_ctrl;

  localparam int TD = 4;
  localparam int DC = 2;
  localparam logic [7:0] WMASK = 8'((1 << DC) - 1);

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_ss = 1'b0, btn_lap = 1'b0, btn_clr = 1'b0;
  logic [7:0] th = 8'd0, tm = 8'd0, ts = 8'd0;
  logic       tmr_ss, tmr_clr, tick;
  logic [7:0] disp_h, disp_m, disp_s;
  logic [1:0] state;

  stopwatch_ctrl #(.TICK_DIV(TD), .DEB_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .btn_ss(btn_ss), .btn_lap(btn_lap), .btn_clr(btn_clr),
    .th(th), .tm(tm), .ts(ts), .tmr_ss(tmr_ss), .tmr_clr(tmr_clr), .tick(tick),
    .disp_h(disp_h), .disp_m(disp_m), .disp_s(disp_s), .state(state)
  );

  always #5 clk = ~clk;

  // Reference model: buttons indexed 0=ss, 1=lap, 2=clr.
  logic [2:0] m_h1 = 3'b0, m_h2 = 3'b0, m_deb = 3'b0, m_ok = 3'b0, m_pend = 3'b0;
  logic [7:0] m_win [3] = '{default: 8'd0};
  int         m_fill [3] = '{default: 0};
  int         m_state = 0, m_runcyc = 0;
  logic       m_ss = 1'b0, m_clr = 1'b0, m_tick = 1'b0, m_live = 1'b0;
  logic [7:0] m_dh = 8'd0, m_dm = 8'd0, m_ds = 8'd0;
  logic [7:0] m_lh = 8'd0, m_lm = 8'd0, m_ls = 8'd0;

  always @(posedge clk) begin : model
    logic [2:0] syn, ev;
    int         old;
    logic       flip;
    syn  = m_h2;
    m_h2 = m_h1;
    m_h1 = {btn_clr, btn_lap, btn_ss};
    ev   = m_pend;
    m_live = 1'b1;
    if (reset) begin
      m_deb = 3'b0; m_ok = 3'b0; m_pend = 3'b0;
      for (int i = 0; i < 3; i++) m_fill[i] = 0;
      m_state = 0; m_runcyc = 0;
      m_ss = 1'b0; m_clr = 1'b0; m_tick = 1'b0;
      {m_dh, m_dm, m_ds} = 24'd0;
      {m_lh, m_lm, m_ls} = 24'd0;
    end else begin
      // a level is accepted once the last DC synchronized samples all disagree with it
      for (int i = 0; i < 3; i++) begin
        if (!syn[i] && !m_deb[i]) m_ok[i] = 1'b1;
        m_win[i]  = {m_win[i][6:0], syn[i]};
        m_fill[i] = m_fill[i] + 1;
        flip = (m_fill[i] >= DC) && (((m_win[i] ^ {8{m_deb[i]}}) & WMASK) == WMASK);
        m_pend[i] = 1'b0;
        if (flip) begin
          m_deb[i]  = ~m_deb[i];
          m_fill[i] = 0;
          m_pend[i] = m_deb[i] & m_ok[i];
        end
      end
      old = m_state;
      m_ss = 1'b0; m_clr = 1'b0; m_tick = 1'b0;
      if (old == 2) {m_dh, m_dm, m_ds} = {m_lh, m_lm, m_ls};
      else          {m_dh, m_dm, m_ds} = {th, tm, ts};
      if (old == 1 || old == 2) begin
        m_runcyc = m_runcyc + 1;
        m_tick   = (m_runcyc % TD) == 0;
      end
      if (ev[2] && old == 3) begin
        m_state = 0; m_clr = 1'b1; m_runcyc = 0;
      end else if (ev[0]) begin
        m_ss = 1'b1;
        m_state = (old == 0 || old == 3) ? 1 : 3;
      end else if (ev[1] && old == 1) begin
        m_state = 2;
        {m_lh, m_lm, m_ls} = {th, tm, ts};
      end else if (ev[1] && old == 2) begin
        m_state = 1;
      end
    end
  end

  int tests = 0, fails = 0, cyc_n = 0;
  int n_ss = 0, n_clr = 0, n_tick = 0;
  logic [28:0] act_v, exp_v;

  task automatic cyc(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      cyc_n++;
      if (tmr_ss === 1'b1)  n_ss++;
      if (tmr_clr === 1'b1) n_clr++;
      if (tick === 1'b1)    n_tick++;
      if (m_live) begin
        tests++;
        act_v = {state, tmr_ss, tmr_clr, tick, disp_h, disp_m, disp_s};
        exp_v = {2'(m_state), m_ss, m_clr, m_tick, m_dh, m_dm, m_ds};
        if (act_v !== exp_v) begin
          fails++;
          $display("FAIL cycle_model @%0d: got st/ss/clr/tick/disp=%h, want %h", cyc_n, act_v, exp_v);
        end
      end
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic press(input logic [2:0] which, input int hold);
    {btn_clr, btn_lap, btn_ss} = which;
    cyc(hold);
    {btn_clr, btn_lap, btn_ss} = 3'b000;
    cyc(6);
  endtask

  task automatic wait_state(input int want, input int limit, input string name);
    int k;
    k = 0;
    while (int'(state) != want && k < limit) begin
      cyc(1);
      k++;
    end
    check(name, int'(state), want);
  endtask

  task automatic wait_tick(input int limit, output int k);
    k = 0;
    do begin
      cyc(1);
      k++;
    end while (tick !== 1'b1 && k < limit);
    if (tick !== 1'b1) begin
      tests++;
      fails++;
      $display("FAIL tick_timeout: got no tick, want one within %0d cycles", limit);
    end
  endtask

  function automatic int outs_all();
    return int'({state, tmr_ss, tmr_clr, tick, disp_h, disp_m, disp_s});
  endfunction

  function automatic int disp_all();
    return int'({disp_h, disp_m, disp_s});
  endfunction

  initial begin
    int k, s, c, t;
    reset = 1'b1;
    cyc(4);
    check("reset_outputs", outs_all(), 0);
    reset = 1'b0;
    ts = 8'd5;
    cyc(3);

    // start from IDLE, tick period
    s = n_ss;
    press(3'b001, 6);
    check("start_state", int'(state), 1);
    check("start_pulses", n_ss - s, 1);
    check("model_pin_running", m_state, 1);
    wait_tick(20, k);
    wait_tick(20, k);
    check("tick_period", k, TD);

    // pause one cycle after a tick boundary, no ticks while paused
    wait_tick(20, k);
    btn_ss = 1'b1;
    cyc(6);
    btn_ss = 1'b0;
    cyc(6);
    check("pause_state", int'(state), 3);
    t = n_tick;
    cyc(20);
    check("no_tick_paused", n_tick - t, 0);

    // bounced resume gives one event; prescaler resumes from its held count
    s = n_ss;
    btn_ss = 1'b1; cyc(1);
    btn_ss = 1'b0; cyc(1);
    btn_ss = 1'b1;
    wait_state(1, 20, "resume_state");
    wait_tick(20, k);
    check("resume_tick_delay", k, 3);
    btn_ss = 1'b0;
    cyc(8);
    check("bounce_one_event", n_ss - s, 1);

    // lap freeze and release
    th = 8'd0; tm = 8'd3; ts = 8'd17;
    cyc(2);
    press(3'b010, 6);
    check("lap_state", int'(state), 2);
    check("lap_disp", disp_all(), 32'h000311);
    check("model_pin_lap", int'({m_dh, m_dm, m_ds}), 32'h000311);
    th = 8'd1; tm = 8'd2; ts = 8'd3;
    cyc(5);
    check("lap_frozen", disp_all(), 32'h000311);
    press(3'b010, 6);
    check("lap_exit_state", int'(state), 1);
    check("live_disp", disp_all(), 32'h010203);

    // simultaneous clr+ss in PAUSED: clr wins
    press(3'b001, 6);
    check("pause2_state", int'(state), 3);
    s = n_ss; c = n_clr;
    press(3'b101, 6);
    check("clr_state", int'(state), 0);
    check("clr_pulse", n_clr - c, 1);
    check("clr_no_ss", n_ss - s, 0);

    // reset in LAP with start/stop held
    press(3'b001, 6);
    press(3'b010, 6);
    check("lap2_state", int'(state), 2);
    btn_ss = 1'b1;
    cyc(1);
    reset = 1'b1;
    cyc(3);
    check("reset_lap_outputs", outs_all(), 0);
    reset = 1'b0;
    s = n_ss;
    cyc(12);
    check("held_no_event_state", int'(state), 0);
    check("held_no_pulse", n_ss - s, 0);
    btn_ss = 1'b0;
    cyc(8);
    press(3'b001, 6);
    check("repress_state", int'(state), 1);
    check("repress_pulse", n_ss - s, 1);
    cyc(4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 50_000_000, meaning clk cycles per timer advance strobe (at least 2).
REQ-002 The block SHALL have parameter DEB_CYCLES, default 500_000, meaning the cycles a synchronized button level must hold stable before it is accepted (at least 1).
REQ-003 clk  in  1  clock; all logic on rising edge.
REQ-004 reset  in  1  reset, synchronous, active-high.
REQ-005 btn_ss  in  1  raw asynchronous start/stop button, active-high.
REQ-006 btn_lap  in  1  raw asynchronous lap button, active-high.
REQ-007 btn_clr  in  1  raw asynchronous clear button, active-high.
REQ-008 th, tm, ts  in  8 each  live hours/minutes/seconds from the timer.
REQ-009 tmr_ss  out  1  one-cycle toggle pulse to the timer's start/stop input.
REQ-010 tmr_clr  out  1  one-cycle pulse to the timer's clear input.
REQ-011 tick  out  1  one-cycle timer advance strobe.
REQ-012 disp_h, disp_m, disp_s  out  8 each  displayed time, either live or frozen lap.
REQ-013 state  out  2  current FSM state.

Function
REQ-014 Each button SHALL pass through a 2-flop synchronizer, then a debounce counter, then a rising-edge detector, yielding a one-cycle event (ev_ss, ev_lap, ev_clr).
REQ-015 A debounced level SHALL change only after the synchronized level has differed from it for DEB_CYCLES consecutive cycles; any bounce restarts the count.
REQ-016 FSM states SHALL be IDLE=0, RUNNING=1, LAP=2, PAUSED=3.
REQ-017 IDLE + ev_ss SHALL go to RUNNING and pulse tmr_ss.
REQ-018 RUNNING + ev_ss SHALL go to PAUSED and pulse tmr_ss.
REQ-019 RUNNING + ev_lap SHALL capture th/tm/ts into lap registers and go to LAP.
REQ-020 LAP + ev_lap SHALL go to RUNNING; LAP + ev_ss SHALL go to PAUSED and pulse tmr_ss.
REQ-021 PAUSED + ev_ss SHALL go to RUNNING and pulse tmr_ss; PAUSED + ev_clr SHALL go to IDLE and pulse tmr_clr.
REQ-022 ev_clr in RUNNING or LAP, and ev_lap in IDLE or PAUSED, SHALL be ignored.
REQ-023 Simultaneous events SHALL be prioritised clr > ss > lap; only the highest-priority valid event SHALL act, and the others SHALL be discarded.
REQ-024 tmr_ss and tmr_clr SHALL assert in the cycle after the event cycle, each for exactly one cycle, and exactly once per transition.
REQ-025 The prescaler SHALL count 0..TICK_DIV-1 only in RUNNING or LAP, and tick SHALL pulse when the count wraps from TICK_DIV-1 to 0.
REQ-026 The prescaler SHALL hold its value in PAUSED, and SHALL clear to 0 on entry to IDLE.
REQ-027 disp_* SHALL show the lap registers in LAP and the registered th/tm/ts otherwise, with one cycle of latency.

Reset
REQ-028 On reset, state SHALL be IDLE, and tmr_ss, tmr_clr, tick, the prescaler, the lap registers and disp_* SHALL all be 0.
REQ-029 On reset, the debounced levels SHALL be 0 and the debounce counters SHALL be 0.
REQ-030 A button held through reset SHALL NOT generate an event until it is released and pressed again.
REQ-031 Reset mid-operation SHALL abort any pending pulse; resetting the timer itself is the system's duty.

Structure
REQ-032 Package stopwatch_pkg SHALL hold the state encoding constants and the default TICK_DIV and DEB_CYCLES values.
REQ-033 Sub-module btn_cond (synchronizer, debounce and edge detect, parameter DEB_CYCLES) SHALL be instantiated three times.
REQ-034 The FSM, prescaler, lap registers and display mux SHALL live in stopwatch_ctrl.

Verification (bench uses TICK_DIV=4, DEB_CYCLES=2)
REQ-035 Press btn_ss from IDLE -> exactly one tmr_ss pulse, state=1, then tick every 4 cycles.
REQ-036 Bounce btn_ss 1-0-1 on single cycles, then hold -> exactly one event.
REQ-037 In RUNNING with th/tm/ts=0/3/17, press lap -> state=2, disp=0/3/17 frozen while the inputs change; press lap again -> state=1 and the display goes live.
REQ-038 In RUNNING, press ss after 2 ticks plus 1 cycle -> state=3, no tick while paused; press ss -> the next tick arrives 3 cycles later.
REQ-039 In PAUSED, press clr and ss in the same cycle -> state=0, one tmr_clr pulse, no tmr_ss pulse.
REQ-040 Assert reset in LAP while btn_ss is held -> all outputs 0, state=0, no event until btn_ss is released and pressed again.
